// File: rtl/ctrl_reg_file_pkg.sv
// ctrl_reg_file_pkg: shared FSM state type and helpers for ctrl_reg_file
package ctrl_reg_file_pkg;
  typedef enum logic {IDLE, CLEAR} state_t;
  localparam int PAR_W = 256;
  function automatic int addr_w(input int depth);
    return ($clog2(depth) > 1) ? $clog2(depth) : 1;
  endfunction
  function automatic logic even_par(input logic [PAR_W-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/ctrl_reg_file_word.sv
// cr_word: one byte-enabled controlled register with a data/RST_VAL load mux
module cr_word #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic             clr,
  input  logic [WIDTH/8-1:0] be,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] merged,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] mask;
  always_comb begin
    mask = '0;
    for (int i = 0; i < WIDTH/8; i++) mask[8*i +: 8] = {8{be[i]}};
  end
  assign merged = (data & mask) | (q & ~mask);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= RST_VAL;
    else if (clr || wr) q <= clr ? RST_VAL : merged;
endmodule

// File: rtl/ctrl_reg_file.sv
// ctrl_reg_file: DEPTH x WIDTH register bank with byte-enabled write, registered read, clear engine
// Optional per-word even parity when CTRL_REG_FILE_PARITY_EN is defined.
module ctrl_reg_file
  import ctrl_reg_file_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int AW = addr_w(DEPTH)
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               wr_en_in,
  input  logic [AW-1:0]      wr_addr_in,
  input  logic [WIDTH/8-1:0] wr_be_in,
  input  logic [WIDTH-1:0]   wr_data_in,
  input  logic               rd_en_in,
  input  logic [AW-1:0]      rd_addr_in,
  output logic [WIDTH-1:0]   rd_data_out,
  output logic               rd_valid_out,
  input  logic               clr_in,
`ifdef CTRL_REG_FILE_PARITY_EN
  input  logic               err_inject_in,
  output logic               parity_err_out,
`endif
  output logic               busy_out
);
  localparam logic [AW:0] DEPTH_A = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH-1);
  state_t state, state_d;
  logic [AW-1:0] cnt, cnt_d;
  logic idle, wr_ok, rd_ok, rd_in, wr_hit;
  logic [WIDTH-1:0] q [DEPTH];
  logic [WIDTH-1:0] merged [DEPTH];
  logic [WIDTH-1:0] rd_word;
  assign idle = state == IDLE;
  assign wr_ok = idle && !clr_in && wr_en_in && ({1'b0, wr_addr_in} < DEPTH_A);
  assign rd_ok = idle && !clr_in && rd_en_in;
  assign rd_in = {1'b0, rd_addr_in} < DEPTH_A;
  assign wr_hit = wr_ok && wr_addr_in == rd_addr_in;
  assign busy_out = !idle;
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    cr_word #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_word (
      .clk(clk_in),
      .rst_n(rst_n_in),
      .wr(wr_ok && wr_addr_in == AW'(g)),
      .clr(state == CLEAR && cnt == AW'(g)),
      .be(wr_be_in),
      .data(wr_data_in),
      .merged(merged[g]),
      .q(q[g])
    );
  end
  // write-first: a same-address write is forwarded from the merge path
  always_comb rd_word = !rd_in ? '0 : wr_hit ? merged[rd_addr_in] : q[rd_addr_in];
  always_comb begin
    state_d = idle ? (clr_in ? CLEAR : IDLE) : (cnt == LAST ? IDLE : CLEAR);
    cnt_d = (idle || cnt == LAST) ? '0 : cnt + 1'b1;
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state <= IDLE;
      cnt <= '0;
      rd_data_out <= '0;
      rd_valid_out <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      rd_valid_out <= rd_ok;
      if (rd_ok) rd_data_out <= rd_word;
    end
`ifdef CTRL_REG_FILE_PARITY_EN
  localparam logic RST_PAR = even_par(PAR_W'(RST_VAL));
  logic [DEPTH-1:0] par;
  logic rd_par;
  always_comb rd_par = !rd_in ? 1'b0 :
                       wr_hit ? even_par(PAR_W'(rd_word)) ^ err_inject_in : par[rd_addr_in];
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      par <= {DEPTH{RST_PAR}};
      parity_err_out <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (state == CLEAR && cnt == AW'(i)) par[i] <= RST_PAR;
        else if (wr_ok && wr_addr_in == AW'(i)) par[i] <= even_par(PAR_W'(merged[i])) ^ err_inject_in;
      parity_err_out <= rd_ok && (even_par(PAR_W'(rd_word)) != rd_par);
    end
`endif
endmodule

// File: tb/tb_ctrl_reg_file.sv
// tb_ctrl_reg_file: directed scoreboard bench for ctrl_reg_file (DEPTH=8 and DEPTH=6 instances)
module tb_ctrl_reg_file;
  logic clk, rst_n, wr_en, rd_en, clr;
  logic [2:0] wr_addr, rd_addr;
  logic [1:0] wr_be;
  logic [15:0] wr_data;
  logic [15:0] rd_data, rd_data6;
  logic rd_valid, rd_valid6, busy, busy6;
  logic [15:0] mem [8];
  logic [15:0] mem6 [8];
  logic [15:0] exp_q [$];
  logic [15:0] exp6_q [$];
  int errors = 0, checks = 0;
  logic exp_perr = 1'b0;
`ifdef CTRL_REG_FILE_PARITY_EN
  logic inj = 1'b0;
  logic perr, perr6;
`endif

  ctrl_reg_file #(.WIDTH(16), .DEPTH(8), .RST_VAL(16'hA5A5)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .wr_en_in(wr_en), .wr_addr_in(wr_addr),
    .wr_be_in(wr_be), .wr_data_in(wr_data), .rd_en_in(rd_en), .rd_addr_in(rd_addr),
    .rd_data_out(rd_data), .rd_valid_out(rd_valid), .clr_in(clr),
`ifdef CTRL_REG_FILE_PARITY_EN
    .err_inject_in(inj), .parity_err_out(perr),
`endif
    .busy_out(busy)
  );

  ctrl_reg_file #(.WIDTH(16), .DEPTH(6), .RST_VAL(16'h0F0F)) dut6 (
    .clk_in(clk), .rst_n_in(rst_n), .wr_en_in(wr_en), .wr_addr_in(wr_addr),
    .wr_be_in(wr_be), .wr_data_in(wr_data), .rd_en_in(rd_en), .rd_addr_in(rd_addr),
    .rd_data_out(rd_data6), .rd_valid_out(rd_valid6), .clr_in(clr),
`ifdef CTRL_REG_FILE_PARITY_EN
    .err_inject_in(inj), .parity_err_out(perr6),
`endif
    .busy_out(busy6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mem[i] = 16'hA5A5;
      mem6[i] = 16'h0F0F;
    end
  endtask

  function automatic void upd(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
    for (int l = 0; l < 2; l++)
      if (be[l]) begin
        mem[a][8*l +: 8] = d[8*l +: 8];
        if (a < 3'd6) mem6[a][8*l +: 8] = d[8*l +: 8];
      end
  endfunction

  task automatic check_read(input string tag);
    chk({tag, "_valid"}, {15'd0, rd_valid}, 16'd1);
    chk({tag, "_data"}, rd_data, exp_q.pop_front());
    chk({tag, "_valid6"}, {15'd0, rd_valid6}, 16'd1);
    chk({tag, "_data6"}, rd_data6, exp6_q.pop_front());
`ifdef CTRL_REG_FILE_PARITY_EN
    chk({tag, "_perr"}, {15'd0, perr}, {15'd0, exp_perr});
    chk({tag, "_perr6"}, {15'd0, perr6}, {15'd0, exp_perr});
`endif
  endtask

  task automatic rd(input logic [2:0] a);
    @(negedge clk);
    rd_en = 1'b1;
    rd_addr = a;
    exp_q.push_back(mem[a]);
    exp6_q.push_back(a < 3'd6 ? mem6[a] : 16'h0000);
    @(negedge clk);
    rd_en = 1'b0;
    check_read($sformatf("rd%0d", a));
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be, input logic also_rd);
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_be = be;
    rd_en = also_rd;
    rd_addr = a;
    upd(a, d, be);
    if (also_rd) begin
      exp_q.push_back(mem[a]);
      exp6_q.push_back(a < 3'd6 ? mem6[a] : 16'h0000);
    end
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (also_rd) check_read($sformatf("bypass%0d", a));
  endtask

  initial begin
    int c8, c6;
    logic rv_bad;
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_be = '0; wr_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_valid", {15'd0, rd_valid}, 16'd0);
    chk("rst_data", rd_data, 16'h0000);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_data6", rd_data6, 16'h0000);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) rd(3'(i));
    @(negedge clk);
    chk("valid_fall", {15'd0, rd_valid}, 16'd0);

    wr(3'd3, 16'h1234, 2'b11, 1'b0);
    wr(3'd3, 16'hFFEE, 2'b01, 1'b0);
    rd(3'd3);
    wr(3'd3, 16'h0000, 2'b00, 1'b0);
    rd(3'd3);
    wr(3'd5, 16'hBEEF, 2'b11, 1'b1);
    rd(3'd5);

    for (int i = 0; i < 8; i++) wr(3'(i), 16'(i * 16'h1111 + 1), 2'b11, 1'b0);
    rd(3'd6);
    @(negedge clk);
    clr = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
    wr_addr = 3'd0; wr_data = 16'h7777; wr_be = 2'b11; rd_addr = 3'd1;
    c8 = 0; c6 = 0; rv_bad = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (busy) c8++;
      if (busy6) c6++;
      if (rd_valid || rd_valid6) rv_bad = 1'b1;
      wr_en = k < 5;
      rd_en = k < 5;
      clr = k == 3;
      wr_addr = 3'(k);
    end
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
    model_reset();
    chk("busy_cycles", 16'(c8), 16'd8);
    chk("busy_cycles6", 16'(c6), 16'd6);
    chk("no_read_in_clear", {15'd0, rv_bad}, 16'd0);
    for (int i = 0; i < 8; i++) rd(3'(i));

    wr(3'd7, 16'h1111, 2'b11, 1'b0);
    wr(3'd2, 16'h2222, 2'b11, 1'b0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_before_rst", {15'd0, busy}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("busy_async_rst", {15'd0, busy}, 16'd0);
    chk("busy6_async_rst", {15'd0, busy6}, 16'd0);
    chk("valid_async_rst", {15'd0, rd_valid}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) rd(3'(i));

    wr(3'd7, 16'h1234, 2'b11, 1'b0);
    rd(3'd7);
    rd(3'd5);

`ifdef CTRL_REG_FILE_PARITY_EN
    inj = 1'b1;
    wr(3'd2, 16'h0001, 2'b11, 1'b0);
    inj = 1'b0;
    exp_perr = 1'b1;
    rd(3'd2);
    exp_perr = 1'b0;
    wr(3'd2, 16'h0001, 2'b11, 1'b0);
    rd(3'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
